// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request arbiter.
// Holds the FSM state encoding and arbitration mode selectors.
package mem_req_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width needed to count 0..t-1 busy cycles; never below one bit.
    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_grant.sv
// Grant selector: first requester at or after ptr (round-robin),
// or lowest index requester when mode is set (fixed priority).
module rr_grant #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = mode ? k : (int'(ptr) + k) % NUM_CH;
            if (!gnt_vld && req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(c);
                gnt[c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Multi-channel memory request arbiter: grants one channel, runs a
// single RAM access with busy wait and timeout, then pulses ready.
module mem_req_arbiter
    import mem_req_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = ARB_RR,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        ready,
    output logic [NUM_CH-1:0]        err,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_wen,
    output logic                     ram_ren,
    input  logic [DATA_W-1:0]        ram_rdata,
    input  logic                     ram_busy,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    g_idx;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_CH-1:0]   gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_vld;
    logic                timed_out;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wen;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_grant (
        .req     (req),
        .ptr     (ptr),
        .mode    (ARB_MODE == ARB_FIXED),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                sel_wen   = wen[i];
            end
        end
    end

    // The busy cycle that brings the count to TIMEOUT ends the access.
    assign timed_out = (TIMEOUT != 0) && ram_busy && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ptr       <= '0;
            g_idx     <= '0;
            cnt       <= '0;
            ready     <= '0;
            err       <= '0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wen   <= 1'b0;
            ram_ren   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            ready <= '0;
            err   <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        g_idx     <= gnt_idx;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_wen   <= sel_wen;
                        ram_ren   <= !sel_wen;
                        busy_o    <= 1'b1;
                        cnt       <= '0;
                        state     <= ACCESS;
                        if (ARB_MODE == ARB_RR) begin
                            ptr <= (gnt_idx == IDX_W'(NUM_CH - 1)) ?
                                   '0 : gnt_idx + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (!ram_busy || timed_out) begin
                        ready[g_idx] <= 1'b1;
                        err[g_idx]   <= timed_out;
                        rdata        <= timed_out ? '0 : ram_rdata;
                        ram_wen      <= 1'b0;
                        ram_ren      <= 1'b0;
                        cnt          <= '0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table, directed
// arbitration/reset sequences and a randomized transaction model.
module tb_mem_req_arbiter;
    import mem_req_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 4;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    wen = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic [DW-1:0]     ram_rdata = '0;
    logic              ram_busy = 1'b0;

    logic [NCH-1:0] ready0, err0, ready1, err1;
    logic [DW-1:0]  rdata0, rdata1, ram_wdata0, ram_wdata1;
    logic [AW-1:0]  ram_addr0, ram_addr1;
    logic           ram_wen0, ram_ren0, busy0;
    logic           ram_wen1, ram_ren1, busy1;

    int total = 0;
    int bad = 0;

    logic        pend [NCH];
    logic        pw   [NCH];
    logic [31:0] pa   [NCH];
    logic [31:0] pd   [NCH];

    typedef struct {
        int          ch;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          nb;
        logic [31:0] rv;
        int          lat;
        logic        e;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(ARB_RR), .TIMEOUT(TO)
    ) u_rr (
        .clk(clk), .nrst(nrst), .req(req), .wen(wen),
        .addr(addr), .wdata(wdata), .ready(ready0), .err(err0),
        .rdata(rdata0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_wen(ram_wen0), .ram_ren(ram_ren0),
        .ram_rdata(ram_rdata), .ram_busy(ram_busy), .busy_o(busy0)
    );

    mem_req_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(ARB_FIXED), .TIMEOUT(TO)
    ) u_fix (
        .clk(clk), .nrst(nrst), .req(req), .wen(wen),
        .addr(addr), .wdata(wdata), .ready(ready1), .err(err1),
        .rdata(rdata1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_wen(ram_wen1), .ram_ren(ram_ren1),
        .ram_rdata(ram_rdata), .ram_busy(ram_busy), .busy_o(busy1)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NCH; i++) begin
            req[i]             = pend[i];
            wen[i]             = pw[i];
            addr[i*AW +: AW]   = pa[i];
            wdata[i*DW +: DW]  = pd[i];
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 1'b0;
            pw[i]   = 1'b0;
            pa[i]   = '0;
            pd[i]   = '0;
        end
        drive_req();
        ram_busy  = 1'b0;
        ram_rdata = '0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    // Runs one transaction on the round-robin instance; caller is in an
    // idle cycle with pend[] describing the held requests.
    task automatic serve(input int ch, input int nb, input logic [31:0] rv,
                         input int lat_exp, input logic e_exp,
                         input logic [31:0] rd_exp);
        logic [NCH-1:0] r_ready, r_err;
        logic [31:0]    r_rdata;
        logic           r_str;
        int             lat;
        logic           ok;
        drive_req();
        ram_busy  = 1'b0;
        ram_rdata = rv;
        lat = 0;
        ok = 1'b1;
        r_ready = '0;
        r_err = '0;
        r_rdata = '0;
        r_str = 1'b0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            step();
            if (ready0 != '0) begin
                lat     = k;
                r_ready = ready0;
                r_err   = err0;
                r_rdata = rdata0;
                r_str   = ram_wen0 | ram_ren0;
            end else if (ram_wen0 !== pw[ch] || ram_ren0 !== !pw[ch] ||
                         ram_addr0 !== pa[ch] || busy0 !== 1'b1 ||
                         (pw[ch] && ram_wdata0 !== pd[ch])) begin
                ok = 1'b0;
            end
            if (k == 1) begin
                addr[ch*AW +: AW]  = ~pa[ch];
                wdata[ch*DW +: DW] = ~pd[ch];
                wen[ch]            = ~pw[ch];
            end
            ram_busy = (k <= nb);
        end
        check("latency", 64'(lat), 64'(lat_exp));
        check("ready", 64'(r_ready), 64'(1 << ch));
        check("err", 64'(r_err), e_exp ? 64'(1 << ch) : 64'(0));
        check("rdata", 64'(r_rdata), 64'(rd_exp));
        check("strobes in access", 64'(ok), 64'(1));
        check("strobes off in resp", 64'(r_str), 64'(0));
        pend[ch] = 1'b0;
        drive_req();
        ram_busy = 1'b0;
        step();
        check("busy_o after resp", 64'(busy0), 64'(0));
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            total++;
            if ((ram_wen0 && ram_ren0) || (ram_wen1 && ram_ren1)) begin
                bad++;
                $display("FAIL strobe overlap: wen=%b%b ren=%b%b",
                         ram_wen0, ram_wen1, ram_ren0, ram_ren1);
            end
        end
    end

    initial begin
        int q0[$];
        int q1[$];
        int mptr, w, nb, lat, ok_n;
        logic e;
        logic [31:0] rv;

        tbl[0] = '{0, 1'b0, 32'h10, 32'h0,  0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{1, 1'b1, 32'h20, 32'h55, 3, 32'h00001234, 5, 1'b0, 32'h00001234};
        tbl[2] = '{0, 1'b0, 32'h30, 32'h0,  9, 32'h0000AAAA, 5, 1'b1, 32'h0};
        tbl[3] = '{0, 1'b0, 32'h44, 32'h0,  0, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
        tbl[4] = '{1, 1'b0, 32'h50, 32'h0,  1, 32'h00000001, 3, 1'b0, 32'h00000001};
        tbl[5] = '{0, 1'b1, 32'h60, 32'hFFFFFFFF, 4, 32'h5, 5, 1'b1, 32'h0};
        tbl[6] = '{1, 1'b1, 32'h70, 32'h12, 2, 32'h00000007, 4, 1'b0, 32'h00000007};

        // Reset with both channels requesting
        nrst = 1'b0;
        req  = 2'b11;
        wen  = 2'b11;
        addr = {32'hAAAA5555, 32'h12345678};
        wdata = {32'hFFFFFFFF, 32'h0F0F0F0F};
        ram_busy = 1'b1;
        ram_rdata = 32'hFFFFFFFF;
        step();
        step();
        check("rst ready", 64'({ready0, ready1}), 64'(0));
        check("rst err", 64'({err0, err1}), 64'(0));
        check("rst rdata", 64'({rdata0, rdata1}), 64'(0));
        check("rst ram_addr", 64'({ram_addr0, ram_addr1}), 64'(0));
        check("rst ram_wdata", 64'({ram_wdata0, ram_wdata1}), 64'(0));
        check("rst strobes", 64'({ram_wen0, ram_ren0, ram_wen1, ram_ren1}), 64'(0));
        check("rst busy_o", 64'({busy0, busy1}), 64'(0));

        // Vector table, one requester at a time
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pend[tbl[i].ch] = 1'b1;
            pw[tbl[i].ch]   = tbl[i].w;
            pa[tbl[i].ch]   = tbl[i].a;
            pd[tbl[i].ch]   = tbl[i].d;
            serve(tbl[i].ch, tbl[i].nb, tbl[i].rv,
                  tbl[i].lat, tbl[i].e, tbl[i].rd);
        end

        // Both channels held high: rotating vs fixed service order
        do_reset();
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        pa[0] = 32'h100;
        pa[1] = 32'h200;
        drive_req();
        for (int k = 1; k <= 13; k++) begin
            step();
            if (ready0 != '0) q0.push_back(ready0[1] ? 1 : 0);
            if (ready1 != '0) q1.push_back(ready1[1] ? 1 : 0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_req();
        check("rr grant count", 64'(q0.size()), 64'(4));
        check("fixed grant count", 64'(q1.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("rr order", 64'((i < q0.size()) ? q0[i] : -1), 64'(i % 2));
            check("fixed order", 64'((i < q1.size()) ? q1[i] : -1), 64'(0));
        end

        // Reset in the middle of a write access
        do_reset();
        pend[0] = 1'b1;
        pa[0] = 32'h80;
        serve(0, 0, 32'h11, 2, 1'b0, 32'h11);
        pend[0] = 1'b1;
        pw[0] = 1'b1;
        pa[0] = 32'h90;
        pd[0] = 32'h77;
        drive_req();
        ram_busy = 1'b1;
        step();
        check("write strobe before reset", 64'(ram_wen0), 64'(1));
        nrst = 1'b0;
        #1;
        check("wen after async reset", 64'(ram_wen0), 64'(0));
        check("busy_o after async reset", 64'(busy0), 64'(0));
        ram_busy = 1'b0;
        step();
        nrst = 1'b1;
        pend[0] = 1'b1;
        pw[0] = 1'b0;
        pa[0] = 32'hA0;
        pend[1] = 1'b1;
        pw[1] = 1'b0;
        pa[1] = 32'hB0;
        serve(0, 0, 32'h21, 2, 1'b0, 32'h21);
        serve(1, 0, 32'h22, 2, 1'b0, 32'h22);

        // Random traffic against a transaction-level pointer model
        do_reset();
        mptr = 0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pw[i]   = 1'($urandom_range(0, 1));
                    pa[i]   = $urandom;
                    pd[i]   = $urandom;
                end
            end
            ok_n = 0;
            for (int i = 0; i < NCH; i++) if (pend[i]) ok_n++;
            if (ok_n == 0) begin
                w = $urandom_range(0, NCH - 1);
                pend[w] = 1'b1;
                pw[w]   = 1'($urandom_range(0, 1));
                pa[w]   = $urandom;
                pd[w]   = $urandom;
            end
            w = -1;
            for (int k = 0; k < NCH; k++) begin
                if (w < 0 && pend[(mptr + k) % NCH]) w = (mptr + k) % NCH;
            end
            mptr = (w + 1) % NCH;
            nb  = $urandom_range(0, 5);
            rv  = $urandom;
            e   = (nb >= TO);
            lat = e ? TO + 1 : nb + 2;
            serve(w, nb, rv, lat, e, e ? 32'h0 : rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, data width.
REQ-004 The block SHALL have parameter ARB_MODE, default 0, where 0 means round-robin and 1 means fixed priority with ch0 highest.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting on ram_busy; 0 disables the timeout.
REQ-006 The block SHALL have port clk  in  1  system clock.
REQ-007 The block SHALL have port nrst  in  1  asynchronous active-low reset.
REQ-008 The block SHALL have port req  in  NUM_CH  per-channel access request.
REQ-009 The block SHALL have port wen  in  NUM_CH  per-channel write (1) or read (0).
REQ-010 The block SHALL have port addr  in  NUM_CH*ADDR_W  flattened channel addresses, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port wdata  in  NUM_CH*DATA_W  flattened channel store data.
REQ-012 The block SHALL have port ready  out  NUM_CH  one-cycle completion pulse per channel.
REQ-013 The block SHALL have port err  out  NUM_CH  one-cycle timeout pulse per channel, coincident with ready.
REQ-014 The block SHALL have port rdata  out  DATA_W  load data, valid while any ready bit is high.
REQ-015 The block SHALL have ports ram_addr out ADDR_W, ram_wdata out DATA_W, ram_wen out 1, ram_ren out 1, forming the RAM request.
REQ-016 The block SHALL have ports ram_rdata in DATA_W and ram_busy in 1, where busy high means the operation is incomplete.
REQ-017 The block SHALL have port busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-019 In IDLE with any req bit high, the block SHALL grant exactly one channel, register that channel's index, addr, wdata and wen, and move to ACCESS.
REQ-020 In ARB_MODE 0, the grant SHALL go to the first requesting channel at or after the priority pointer, and the pointer SHALL advance to the granted index plus 1, wrapping from NUM_CH-1 to 0.
REQ-021 In ARB_MODE 1, the grant SHALL go to the lowest-index requesting channel, and the pointer SHALL be unused.
REQ-022 In ACCESS, the block SHALL drive ram_addr and ram_wdata from the registered values, assert ram_wen when the captured wen is 1, and otherwise assert ram_ren.
REQ-023 In ACCESS, when ram_busy is sampled low, the block SHALL capture ram_rdata into rdata, move to RESP, and reset the wait counter.
REQ-024 In ACCESS, a wait counter SHALL increment each cycle ram_busy is high; when it reaches TIMEOUT (TIMEOUT nonzero), the block SHALL move to RESP with the err flag set and rdata forced to 0.
REQ-025 In RESP, the block SHALL pulse ready[g] (and err[g] when the err flag is set) for exactly one cycle, deassert the RAM strobes, and return to IDLE.
REQ-026 The best-case latency SHALL be 2 cycles: req sampled in cycle 0 gives ready in cycle 2; each additional cycle of ram_busy adds one cycle.
REQ-027 Changes to req, addr, wdata or wen after the grant SHALL NOT affect the operation in flight.
REQ-028 A requester SHALL hold req until it sees ready, then deassert it; a req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-029 ram_wen and ram_ren SHALL never be high together, and both SHALL be low outside ACCESS.
REQ-030 Simultaneous requests SHALL be served one per transaction in arbitration order, with no channel starving in mode 0.

Reset
REQ-031 On nrst low, at any time including mid-transaction, the block SHALL go to IDLE.
REQ-032 On nrst low, the pointer, wait counter and err flag SHALL be set to 0.
REQ-033 On nrst low, ready, err, rdata, ram_addr, ram_wdata, ram_wen, ram_ren and busy_o SHALL all be 0.

Structure
REQ-034 The state enum and the ARB_MODE constants SHALL be defined in the shared package mem_req_pkg.
REQ-035 Grant selection SHALL be a sub-module rr_grant (inputs: req, pointer, mode; output: one-hot grant plus index).

Verification
REQ-036 Reset: with nrst low and req=2'b11, all outputs SHALL be 0 and the state SHALL be IDLE.
REQ-037 Single read: ch0 reads addr 0x10, ram_busy=0, ram_rdata=0xDEADBEEF -> ram_ren high in cycle 1, ready[0] high in cycle 2, rdata=0xDEADBEEF.
REQ-038 Round-robin: req=2'b11 held continuously in mode 0 -> grants SHALL be served in the order ch0, ch1, ch0, ch1; in mode 1 with the same stimulus, ch0 SHALL be served every time.
REQ-039 Write with busy: ch1 writes 0x55 to 0x20 while ram_busy is held high for 3 cycles -> ram_wen high for 4 cycles, ready[1] in cycle 5, ram_ren never high.
REQ-040 Timeout: TIMEOUT=4 with ram_busy stuck high -> err[0] and ready[0] pulse together, rdata=0, the block returns to IDLE, and the next request is served normally.
REQ-041 Reset mid-ACCESS: asserting nrst in cycle 1 of a write -> ram_wen drops immediately, busy_o=0, and the pointer returns to 0.
